// File: rtl/ft232h_bridge_pkg.sv
// ============================================================================
// Module      : ft232h_bridge_pkg
// Description : Shared types, widths and helpers for the FT232H sync-245 bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ft232h_bridge_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX_OE   = 2'd1,
        RX_READ = 2'd2,
        TX      = 2'd3
    } state_e;

    localparam logic [1:0] c_ST_IDLE    = IDLE;
    localparam logic [1:0] c_ST_RX_OE   = RX_OE;
    localparam logic [1:0] c_ST_RX_READ = RX_READ;
    localparam logic [1:0] c_ST_TX      = TX;

    // Wide enough to hold the burst limit itself.
    function automatic int burst_cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ft232h_tx_prefetch.sv
// ============================================================================
// Module      : ft232h_tx_prefetch
// Description : One-byte prefetch/hold stage between the TX FIFO read port
//               and the FT232H write side, giving 1 byte/clk with retry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft232h_tx_prefetch
    import ft232h_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic [BYTE_W-1:0] dout,
    input  logic              i_accept,
    output logic              rd_en,
    output logic              o_tx_valid,
    output logic [BYTE_W-1:0] o_tx_data
);

    logic              r_fetch_pending;
    logic              r_hold_valid;
    logic [BYTE_W-1:0] r_hold;

    // A fetched byte and a held byte never coexist, so the mux is a simple select.
    assign o_tx_valid = r_hold_valid | r_fetch_pending;
    assign o_tx_data  = r_fetch_pending ? dout : r_hold;
    assign rd_en      = ~rst & ~empty & (~o_tx_valid | i_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pending <= 1'b0;
            r_hold_valid    <= 1'b0;
            r_hold          <= '0;
        end else begin
            r_fetch_pending <= rd_en;
            if (r_fetch_pending && !i_accept) begin
                r_hold       <= dout;
                r_hold_valid <= 1'b1;
            end else if (i_accept) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ft232h_bridge.sv
// ============================================================================
// Module      : ft232h_bridge
// Description : Bridges internal RX/TX byte FIFOs to an FT232H in synchronous
//               245 FIFO mode; owns the adbus direction. Optional macro
//               FT232H_SIWU_EN adds a siwu_n send-immediate pulse output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft232h_bridge
    import ft232h_bridge_pkg::*;
#(
    parameter int TX_BURST_MAX = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    output logic              rd_en,
    input  logic [BYTE_W-1:0] dout,
    input  logic              full,
    output logic              wr_en,
    output logic [BYTE_W-1:0] din,
    input  logic              txe_n,
    output logic              wr_n,
    input  logic              rxf_n,
    output logic              oe_n,
    output logic              rd_n,
`ifdef FT232H_SIWU_EN
    output logic              siwu_n,
`endif
    inout  wire  [BYTE_W-1:0] adbus
);

    localparam int                 c_CNT_W     = burst_cnt_width(TX_BURST_MAX);
    localparam logic [c_CNT_W-1:0] c_BURST_MAX = c_CNT_W'(TX_BURST_MAX);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_burst_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_tx_valid;
    logic [BYTE_W-1:0]  w_tx_data;
    logic               w_accept;
    logic               w_rx_req;
    logic               w_in_tx;
    logic               w_tx_dry;
    logic               w_burst_hit;

    ft232h_tx_prefetch u_tx_prefetch (
        .clk        (clk),
        .rst        (rst),
        .empty      (empty),
        .dout       (dout),
        .i_accept   (w_accept),
        .rd_en      (rd_en),
        .o_tx_valid (w_tx_valid),
        .o_tx_data  (w_tx_data)
    );

    assign w_rx_req = ~rxf_n & ~full;
    assign w_in_tx  = (r_state == c_ST_TX);
    assign w_tx_dry = ~w_tx_valid & empty;

    assign oe_n  = ~((r_state == c_ST_RX_OE) | (r_state == c_ST_RX_READ));
    assign rd_n  = (r_state == c_ST_RX_READ) ? full : 1'b1;
    assign wr_en = (r_state == c_ST_RX_READ) & w_rx_req;
    assign din   = adbus;

    assign wr_n     = ~(w_in_tx & w_tx_valid & ~txe_n);
    assign w_accept = ~wr_n;
    assign adbus    = w_in_tx ? w_tx_data : {BYTE_W{1'bz}};

    // Count including the byte accepted this edge, so the limit is never overshot.
    assign w_cnt_inc   = (r_burst_cnt == c_BURST_MAX) ? r_burst_cnt
                                                      : r_burst_cnt + {{(c_CNT_W-1){1'b0}}, w_accept};
    assign w_burst_hit = w_rx_req & (w_cnt_inc == c_BURST_MAX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rx_req)
                    w_state_next = c_ST_RX_OE;
                else if (~txe_n & (w_tx_valid | ~empty))
                    w_state_next = c_ST_TX;
            end
            c_ST_RX_OE:   w_state_next = c_ST_RX_READ;
            c_ST_RX_READ: if (rxf_n | full) w_state_next = c_ST_IDLE;
            c_ST_TX:      if (txe_n | w_tx_dry | w_burst_hit) w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_ST_IDLE && w_state_next == c_ST_TX)
                r_burst_cnt <= '0;
            else if (w_in_tx)
                r_burst_cnt <= w_cnt_inc;
        end
    end

`ifdef FT232H_SIWU_EN
    logic r_siwu_n;

    // Flush the FT232H buffer when a non-empty burst ends for lack of data.
    always_ff @(posedge clk) begin
        if (rst)
            r_siwu_n <= 1'b1;
        else
            r_siwu_n <= ~(w_in_tx & w_tx_dry & (r_burst_cnt != '0));
    end

    assign siwu_n = r_siwu_n;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ft232h_bridge.sv
// ============================================================================
// Module      : tb_ft232h_bridge
// Description : Scoreboard bench for ft232h_bridge with TX FIFO, RX FIFO and
//               FT232H host models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ft232h_bridge;

    localparam int c_BURST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       wr_en;
    logic [7:0] din;
    logic       txe_n;
    logic       wr_n;
    logic       rxf_n;
    logic       oe_n;
    logic       rd_n;
    logic [7:0] host_byte;
    wire  [7:0] adbus;
`ifdef FT232H_SIWU_EN
    logic       siwu_n;
`endif

    always #5 clk = ~clk;

    // The FT232H drives the bus whenever its output enable is asserted.
    assign adbus = oe_n ? 8'bz : host_byte;

    ft232h_bridge #(.TX_BURST_MAX(c_BURST)) dut (
        .clk   (clk),
        .rst   (rst),
        .empty (empty),
        .rd_en (rd_en),
        .dout  (dout),
        .full  (full),
        .wr_en (wr_en),
        .din   (din),
        .txe_n (txe_n),
        .wr_n  (wr_n),
        .rxf_n (rxf_n),
        .oe_n  (oe_n),
        .rd_n  (rd_n),
`ifdef FT232H_SIWU_EN
        .siwu_n(siwu_n),
`endif
        .adbus (adbus)
    );

    logic [7:0] tx_q[$];
    logic [7:0] host_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   acc_cnt   = 0;
    int   rx_cnt    = 0;
    int   first_acc = -1;
    int   last_acc  = -1;
    logic prev_oe_n = 1'b1;
    logic prev_wr_n = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic refresh();
        empty     = (tx_q.size() == 0);
        rxf_n     = (host_q.size() == 0);
        host_byte = (host_q.size() != 0) ? host_q[0] : 8'h00;
    endtask

    task automatic load_tx(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            tx_q.push_back(first + 8'(i));
            exp_tx.push_back(first + 8'(i));
        end
        refresh();
    endtask

    task automatic load_host(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            host_q.push_back(first + 8'(i));
            exp_rx.push_back(first + 8'(i));
        end
        refresh();
    endtask

    // Called at a falling edge: observe what the next rising edge will do,
    // then apply that edge's effect on the FIFO and host models.
    task automatic cycle();
        logic       ev_rd_en;
        logic       ev_host;
        logic [7:0] e;
        #1;
        if (!wr_n) begin
            chk("tx_txe", txe_n, 0);
            chk("tx_oe", oe_n, 1);
            chk("tx_avail", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) begin
                e = exp_tx.pop_front();
                chk("tx_data", adbus, e);
            end
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            acc_cnt++;
        end
        if (wr_en || !rd_n) chk("rx_strobe", wr_en, !rd_n && !rxf_n);
        if (!rd_n) chk("rx_oe_lead", prev_oe_n, 0);
        if (wr_en) begin
            chk("rx_avail", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) begin
                e = exp_rx.pop_front();
                chk("rx_data", din, e);
            end
            rx_cnt++;
        end
        if (!oe_n && prev_oe_n) chk("rx_turn", prev_wr_n, 1);
        ev_rd_en  = rd_en;
        ev_host   = !rd_n && !rxf_n;
        prev_oe_n = oe_n;
        prev_wr_n = wr_n;
        @(negedge clk);
        cyc++;
        if (ev_rd_en) begin
            chk("pop_nonempty", tx_q.size() != 0, 1);
            if (tx_q.size() != 0) dout = tx_q.pop_front();
        end
        if (ev_host && host_q.size() != 0) void'(host_q.pop_front());
        refresh();
    endtask

    task automatic wait_acc(input int n, input int bound);
        for (int i = 0; i < bound && acc_cnt < n; i++) cycle();
        chk("wait_acc", acc_cnt >= n, 1);
    endtask

    task automatic wait_rx(input int n, input int bound);
        for (int i = 0; i < bound && rx_cnt < n; i++) cycle();
        chk("wait_rx", rx_cnt >= n, 1);
    endtask

    task automatic drain(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (exp_tx.size() == 0 && exp_rx.size() == 0 && oe_n && wr_n) break;
            cycle();
        end
        chk("drain", i < bound, 1);
        cycle();
        cycle();
    endtask

    initial begin
        rst   = 1'b1;
        full  = 1'b0;
        txe_n = 1'b1;
        dout  = 8'h00;
        refresh();
        @(negedge clk);

        // 1: reset state
        cycle();
        cycle();
        chk("rst_oe_n", oe_n, 1);
        chk("rst_rd_n", rd_n, 1);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        rst = 1'b0;
        cycle();

        // 2: plain 8-byte TX burst
        acc_cnt = 0; first_acc = -1;
        txe_n = 1'b0;
        load_tx(8'h10, 8);
        drain(60);
        chk("t2_count", acc_cnt, 8);
        chk("t2_span", last_acc - first_acc, 7);
        chk("t2_empty", empty, 1);
        chk("t2_idle_oe", oe_n, 1);

        // 3: three RX bytes
        rx_cnt = 0;
        load_host(8'hA0, 3);
        wait_rx(3, 30);
        drain(30);
        chk("t3_count", rx_cnt, 3);
        chk("t3_oe_n", oe_n, 1);
        chk("t3_rd_n", rd_n, 1);

        // 4: txe_n stall mid-burst; 0x13 must be retried without loss
        acc_cnt = 0;
        load_tx(8'h10, 8);
        wait_acc(3, 30);
        txe_n = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("t4_stall_wr_n", wr_n, 1);
        chk("t4_stall_count", acc_cnt, 3);
        txe_n = 1'b0;
        drain(60);
        chk("t4_count", acc_cnt, 8);

        // 5: RX FIFO full after two bytes
        rx_cnt = 0;
        load_host(8'hB0, 3);
        wait_rx(2, 30);
        full = 1'b1;
        cycle();
        chk("t5_rd_n", rd_n, 1);
        chk("t5_wr_en", wr_en, 0);
        cycle();
        cycle();
        chk("t5_stall_count", rx_cnt, 2);
        full = 1'b0;
        drain(30);
        chk("t5_count", rx_cnt, 3);

        // 6: RX request during a TX burst; yield after TX_BURST_MAX accepts
        acc_cnt = 0; rx_cnt = 0;
        load_tx(8'h20, 8);
        wait_acc(1, 30);
        load_host(8'hC0, 2);
        for (int i = 0; i < 30 && oe_n; i++) cycle();
        chk("t6_rx_start", oe_n, 0);
        chk("t6_burst", acc_cnt, c_BURST);
        drain(80);
        chk("t6_tx_count", acc_cnt, 8);
        chk("t6_rx_count", rx_cnt, 2);

        chk("tx_left", exp_tx.size(), 0);
        chk("rx_left", exp_rx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
